// File: rtl/fpu_transfer_sched_if.sv
// Bus between the transfer scheduler, its two requesters, the combinational
// transfer/classify datapath and the response consumer.
interface fpu_transfer_sched_if #(
  parameter int TAG_W = 4
) ();
  logic             REQ0_VALID;
  logic             REQ0_READY;
  logic [2:0]       REQ0_OP;
  logic             REQ0_SP_DP;
  logic [63:0]      REQ0_DATA;
  logic [TAG_W-1:0] REQ0_TAG;

  logic             REQ1_VALID;
  logic             REQ1_READY;
  logic [2:0]       REQ1_OP;
  logic             REQ1_SP_DP;
  logic [63:0]      REQ1_DATA;
  logic [TAG_W-1:0] REQ1_TAG;

  logic [63:0]      XFER_INPUT;
  logic             XFER_SP_DP;
  logic [2:0]       XFER_OPERATION;
  logic [31:0]      XFER_OUTPUT;

  logic             RSP_VALID;
  logic             RSP_READY;
  logic [31:0]      RSP_DATA;
  logic [TAG_W-1:0] RSP_TAG;
  logic             RSP_SRC;
  logic             RSP_LAST;
  logic             RSP_ILLEGAL;

  // Scheduler side.
  modport slave (
    input  REQ0_VALID, REQ0_OP, REQ0_SP_DP, REQ0_DATA, REQ0_TAG,
    input  REQ1_VALID, REQ1_OP, REQ1_SP_DP, REQ1_DATA, REQ1_TAG,
    input  XFER_OUTPUT, RSP_READY,
    output REQ0_READY, REQ1_READY,
    output XFER_INPUT, XFER_SP_DP, XFER_OPERATION,
    output RSP_VALID, RSP_DATA, RSP_TAG, RSP_SRC, RSP_LAST, RSP_ILLEGAL
  );

  // Environment side: requesters, datapath and response consumer.
  modport master (
    output REQ0_VALID, REQ0_OP, REQ0_SP_DP, REQ0_DATA, REQ0_TAG,
    output REQ1_VALID, REQ1_OP, REQ1_SP_DP, REQ1_DATA, REQ1_TAG,
    output XFER_OUTPUT, RSP_READY,
    input  REQ0_READY, REQ1_READY,
    input  XFER_INPUT, XFER_SP_DP, XFER_OPERATION,
    input  RSP_VALID, RSP_DATA, RSP_TAG, RSP_SRC, RSP_LAST, RSP_ILLEGAL
  );
endinterface

// File: rtl/fpu_transfer_sched.sv
// Round-robin scheduler/sequencer for the FPU transfer/classify datapath;
// splits DP FP-to-int moves into a low-word beat and a high-word beat.
module fpu_transfer_sched #(
  parameter int TAG_W = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  fpu_transfer_sched_if.slave   bus
);

  localparam logic [2:0] OP_MOV_INT_FP = 3'b000;
  localparam logic [2:0] OP_MOV_FP_INT = 3'b001;
  localparam logic [2:0] OP_FCLASS     = 3'b100;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             hi_q, hi_d;
  logic [63:0]      data_q, data_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             src_q, src_d;

  logic [63:0]      xfer_input_q, xfer_input_d;
  logic             xfer_sp_dp_q, xfer_sp_dp_d;
  logic [2:0]       xfer_op_q, xfer_op_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_src_q, rsp_src_d;
  logic             rsp_last_q, rsp_last_d;
  logic             rsp_illegal_q, rsp_illegal_d;

  logic             gnt_idx;
  logic             accept;
  logic             legal;
  logic             two_beat;

  // prio_q names the port that wins a tie next, so port 0 wins first after reset
  // and each accept hands the tie to the other port.
  always_comb begin
    gnt_idx = (bus.REQ0_VALID && bus.REQ1_VALID) ? prio_q : bus.REQ1_VALID;
    accept  = RST_N && (state_q == IDLE) && (bus.REQ0_VALID || bus.REQ1_VALID);
  end

  assign bus.REQ0_READY = accept && !gnt_idx;
  assign bus.REQ1_READY = accept && gnt_idx;

  assign legal    = (xfer_op_q == OP_MOV_INT_FP) || (xfer_op_q == OP_MOV_FP_INT) ||
                    (xfer_op_q == OP_FCLASS);
  assign two_beat = (xfer_op_q == OP_MOV_FP_INT) && xfer_sp_dp_q && legal;

  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    hi_d          = hi_q;
    data_d        = data_q;
    tag_d         = tag_q;
    src_d         = src_q;
    xfer_input_d  = xfer_input_q;
    xfer_sp_dp_d  = xfer_sp_dp_q;
    xfer_op_d     = xfer_op_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_src_d     = rsp_src_q;
    rsp_last_d    = rsp_last_q;
    rsp_illegal_d = rsp_illegal_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d       = gnt_idx ? bus.REQ1_DATA  : bus.REQ0_DATA;
          tag_d        = gnt_idx ? bus.REQ1_TAG   : bus.REQ0_TAG;
          xfer_op_d    = gnt_idx ? bus.REQ1_OP    : bus.REQ0_OP;
          xfer_sp_dp_d = gnt_idx ? bus.REQ1_SP_DP : bus.REQ0_SP_DP;
          xfer_input_d = data_d;
          src_d        = gnt_idx;
          prio_d       = !gnt_idx;
          hi_d         = 1'b0;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_valid_d   = 1'b1;
        rsp_data_d    = legal ? bus.XFER_OUTPUT : 32'h0;
        rsp_tag_d     = tag_q;
        rsp_src_d     = src_q;
        rsp_illegal_d = !legal;
        rsp_last_d    = !two_beat || hi_q;
        state_d       = RESP;
      end
      RESP: begin
        if (bus.RSP_READY) begin
          rsp_valid_d = 1'b0;
          if (rsp_last_q) begin
            state_d = IDLE;
          end else begin
            // High word is presented in the low half for the second pass.
            hi_d         = 1'b1;
            xfer_input_d = {32'h0, data_q[63:32]};
            state_d      = EXEC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      prio_q        <= 1'b0;
      hi_q          <= 1'b0;
      data_q        <= '0;
      tag_q         <= '0;
      src_q         <= 1'b0;
      xfer_input_q  <= '0;
      xfer_sp_dp_q  <= 1'b0;
      xfer_op_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_tag_q     <= '0;
      rsp_src_q     <= 1'b0;
      rsp_last_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      hi_q          <= hi_d;
      data_q        <= data_d;
      tag_q         <= tag_d;
      src_q         <= src_d;
      xfer_input_q  <= xfer_input_d;
      xfer_sp_dp_q  <= xfer_sp_dp_d;
      xfer_op_q     <= xfer_op_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_src_q     <= rsp_src_d;
      rsp_last_q    <= rsp_last_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign bus.XFER_INPUT     = xfer_input_q;
  assign bus.XFER_SP_DP     = xfer_sp_dp_q;
  assign bus.XFER_OPERATION = xfer_op_q;
  assign bus.RSP_VALID      = rsp_valid_q;
  assign bus.RSP_DATA       = rsp_data_q;
  assign bus.RSP_TAG        = rsp_tag_q;
  assign bus.RSP_SRC        = rsp_src_q;
  assign bus.RSP_LAST       = rsp_last_q;
  assign bus.RSP_ILLEGAL    = rsp_illegal_q;

endmodule

// File: tb/tb_fpu_transfer_sched.sv
// Directed bench for fpu_transfer_sched with a small combinational model of
// the transfer/classify datapath driving XFER_OUTPUT.
module tb_fpu_transfer_sched;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  fpu_transfer_sched_if #(.TAG_W(4)) bus ();

  fpu_transfer_sched #(.TAG_W(4)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fclass_sp(input logic [31:0] f);
    logic [3:0] b;
    if (f[30:23] == 8'hFF)
      b = (f[22:0] == 23'h0) ? (f[31] ? 4'd0 : 4'd7) : (f[22] ? 4'd9 : 4'd8);
    else if (f[30:23] == 8'h00)
      b = (f[22:0] == 23'h0) ? (f[31] ? 4'd3 : 4'd4) : (f[31] ? 4'd2 : 4'd5);
    else
      b = f[31] ? 4'd1 : 4'd6;
    return 32'd1 << b;
  endfunction

  // Datapath model; illegal ops produce a non-zero value the scheduler must mask.
  always_comb begin
    case (bus.XFER_OPERATION)
      3'b000, 3'b001: bus.XFER_OUTPUT = bus.XFER_INPUT[31:0];
      3'b100:         bus.XFER_OUTPUT = fclass_sp(bus.XFER_INPUT[31:0]);
      default:        bus.XFER_OUTPUT = 32'hDEAD_BEEF | bus.XFER_INPUT[63:32] |
                                        {31'h0, bus.XFER_SP_DP};
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic v, input logic [2:0] op,
                         input logic sp, input logic [63:0] d, input logic [3:0] tag);
    if (port == 0) begin
      bus.REQ0_VALID = v; bus.REQ0_OP = op; bus.REQ0_SP_DP = sp;
      bus.REQ0_DATA = d;  bus.REQ0_TAG = tag;
    end else begin
      bus.REQ1_VALID = v; bus.REQ1_OP = op; bus.REQ1_SP_DP = sp;
      bus.REQ1_DATA = d;  bus.REQ1_TAG = tag;
    end
  endtask

  // Presents one request, waits (bounded) for its READY, and returns in the
  // cycle right after the accepting edge with the request withdrawn.
  task automatic issue(input int port, input logic [2:0] op, input logic sp,
                       input logic [63:0] d, input logic [3:0] tag);
    logic ok;
    set_req(port, 1'b1, op, sp, d, tag);
    #1;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((port == 0) ? bus.REQ0_READY : bus.REQ1_READY) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL issue_ready port=%0d: READY=0 after 8 cycles, required 1", port);
    end
    tick();
    set_req(port, 1'b0, 3'b000, 1'b0, 64'h0, 4'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(0, 1'b1, 3'b100, 1'b0, 64'h1, 4'h1);
    set_req(1, 1'b1, 3'b100, 1'b0, 64'h2, 4'h2);
    bus.RSP_READY = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.REQ0_READY, bus.REQ1_READY} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b, required 00", {bus.REQ0_READY, bus.REQ1_READY});
    end
    checks++;
    if (bus.RSP_VALID !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_valid: got %b, required 0", bus.RSP_VALID);
    end
    checks++;
    if ({bus.XFER_INPUT, bus.XFER_OPERATION, bus.XFER_SP_DP} !== 68'h0) begin
      errors++; $display("FAIL reset_xfer: input=%h op=%b sp=%b, required all 0",
                         bus.XFER_INPUT, bus.XFER_OPERATION, bus.XFER_SP_DP);
    end
    checks++;
    if ({bus.RSP_DATA, bus.RSP_TAG, bus.RSP_SRC, bus.RSP_LAST, bus.RSP_ILLEGAL} !== 39'h0) begin
      errors++; $display("FAIL reset_rsp_fields: data=%h tag=%h src=%b last=%b ill=%b, required all 0",
                         bus.RSP_DATA, bus.RSP_TAG, bus.RSP_SRC, bus.RSP_LAST, bus.RSP_ILLEGAL);
    end
    set_req(0, 1'b0, 3'b000, 1'b0, 64'h0, 4'h0);
    set_req(1, 1'b0, 3'b000, 1'b0, 64'h0, 4'h0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fclass_port0();
    issue(0, 3'b100, 1'b0, 64'h0000_0000_7F80_0000, 4'h5);
    checks++;
    if (bus.RSP_VALID !== 1'b0) begin
      errors++; $display("FAIL fclass_t1_valid: got %b, required 0", bus.RSP_VALID);
    end
    checks++;
    if (bus.XFER_INPUT !== 64'h0000_0000_7F80_0000 || bus.XFER_OPERATION !== 3'b100) begin
      errors++; $display("FAIL fclass_xfer: input=%h op=%b, required 000000007f800000 100",
                         bus.XFER_INPUT, bus.XFER_OPERATION);
    end
    tick();
    checks++;
    if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 32'h0000_0080 || bus.RSP_LAST !== 1'b1 ||
        bus.RSP_SRC !== 1'b0 || bus.RSP_TAG !== 4'h5 || bus.RSP_ILLEGAL !== 1'b0) begin
      errors++; $display("FAIL fclass_beat: v=%b data=%h last=%b src=%b tag=%h ill=%b, required 1 00000080 1 0 5 0",
                         bus.RSP_VALID, bus.RSP_DATA, bus.RSP_LAST, bus.RSP_SRC, bus.RSP_TAG, bus.RSP_ILLEGAL);
    end
    tick();
    checks++;
    if (bus.RSP_VALID !== 1'b0) begin
      errors++; $display("FAIL fclass_drop: RSP_VALID=%b, required 0", bus.RSP_VALID);
    end
  endtask

  task automatic test_dp_move();
    issue(1, 3'b001, 1'b1, 64'h1234_5678_9ABC_DEF0, 4'hA);
    tick();
    checks++;
    if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 32'h9ABC_DEF0 || bus.RSP_LAST !== 1'b0 ||
        bus.RSP_SRC !== 1'b1 || bus.RSP_TAG !== 4'hA) begin
      errors++; $display("FAIL dp_beat1: v=%b data=%h last=%b src=%b tag=%h, required 1 9abcdef0 0 1 a",
                         bus.RSP_VALID, bus.RSP_DATA, bus.RSP_LAST, bus.RSP_SRC, bus.RSP_TAG);
    end
    tick();
    checks++;
    if (bus.RSP_VALID !== 1'b0 || bus.XFER_INPUT !== 64'h0000_0000_1234_5678) begin
      errors++; $display("FAIL dp_hi_exec: v=%b input=%h, required 0 0000000012345678",
                         bus.RSP_VALID, bus.XFER_INPUT);
    end
    tick();
    checks++;
    if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 32'h1234_5678 || bus.RSP_LAST !== 1'b1 ||
        bus.RSP_TAG !== 4'hA) begin
      errors++; $display("FAIL dp_beat2: v=%b data=%h last=%b tag=%h, required 1 12345678 1 a",
                         bus.RSP_VALID, bus.RSP_DATA, bus.RSP_LAST, bus.RSP_TAG);
    end
    tick();
    checks++;
    if (bus.RSP_VALID !== 1'b0) begin
      errors++; $display("FAIL dp_drop: RSP_VALID=%b, required 0", bus.RSP_VALID);
    end
  endtask

  task automatic test_illegal();
    issue(0, 3'b010, 1'b0, 64'h0000_0000_0000_0055, 4'h3);
    tick();
    checks++;
    if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 32'h0 || bus.RSP_ILLEGAL !== 1'b1 ||
        bus.RSP_LAST !== 1'b1 || bus.RSP_TAG !== 4'h3) begin
      errors++; $display("FAIL illegal_beat: v=%b data=%h ill=%b last=%b tag=%h, required 1 00000000 1 1 3",
                         bus.RSP_VALID, bus.RSP_DATA, bus.RSP_ILLEGAL, bus.RSP_LAST, bus.RSP_TAG);
    end
    tick();
    issue(0, 3'b000, 1'b1, 64'hFFFF_FFFF_0000_1111, 4'h7);
    tick();
    checks++;
    if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 32'h0000_1111 || bus.RSP_ILLEGAL !== 1'b0 ||
        bus.RSP_LAST !== 1'b1 || bus.RSP_TAG !== 4'h7) begin
      errors++; $display("FAIL after_illegal: v=%b data=%h ill=%b last=%b tag=%h, required 1 00001111 0 1 7",
                         bus.RSP_VALID, bus.RSP_DATA, bus.RSP_ILLEGAL, bus.RSP_LAST, bus.RSP_TAG);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bus.RSP_READY = 1'b0;
    issue(1, 3'b100, 1'b0, 64'h0000_0000_FF80_0000, 4'h9);
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 32'h0000_0001 || bus.RSP_TAG !== 4'h9 ||
          bus.RSP_LAST !== 1'b1 || bus.RSP_SRC !== 1'b1) begin
        errors++; $display("FAIL bp_hold cycle=%0d: v=%b data=%h tag=%h last=%b src=%b, required 1 00000001 9 1 1",
                           i, bus.RSP_VALID, bus.RSP_DATA, bus.RSP_TAG, bus.RSP_LAST, bus.RSP_SRC);
      end
      tick();
    end
    bus.RSP_READY = 1'b1;
    tick();
    checks++;
    if (bus.RSP_VALID !== 1'b0) begin
      errors++; $display("FAIL bp_release: RSP_VALID=%b, required 0", bus.RSP_VALID);
    end
  endtask

  task automatic test_back_to_back();
    int  n;
    logic exp_src;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_req(0, 1'b1, 3'b100, 1'b0, 64'h0000_0000_7F80_0000, 4'h1);
    set_req(1, 1'b1, 3'b100, 1'b0, 64'h0000_0000_FF80_0000, 4'h2);
    #1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      exp_src = ((c / 3) % 2) == 1;
      if (bus.REQ0_READY || bus.REQ1_READY) begin
        checks++;
        if (c != 3 * n || bus.REQ1_READY !== exp_src || (bus.REQ0_READY && bus.REQ1_READY)) begin
          errors++; $display("FAIL rr_grant cycle=%0d: ready0=%b ready1=%b, required grant %0d at cycle %0d",
                             c, bus.REQ0_READY, bus.REQ1_READY, n % 2, 3 * n);
        end
        n++;
      end
      if ((c % 3) == 2) begin
        checks++;
        if (bus.RSP_VALID !== 1'b1 || bus.RSP_SRC !== exp_src ||
            bus.RSP_DATA !== (exp_src ? 32'h0000_0001 : 32'h0000_0080)) begin
          errors++; $display("FAIL rr_rsp cycle=%0d: v=%b src=%b data=%h, required 1 %b %h",
                             c, bus.RSP_VALID, bus.RSP_SRC, bus.RSP_DATA, exp_src,
                             exp_src ? 32'h0000_0001 : 32'h0000_0080);
        end
      end
      tick();
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL rr_count: grants=%0d, required 4", n);
    end
    set_req(0, 1'b0, 3'b000, 1'b0, 64'h0, 4'h0);
    set_req(1, 1'b0, 3'b000, 1'b0, 64'h0, 4'h0);
    tick();
  endtask

  task automatic test_reset_mid();
    issue(0, 3'b001, 1'b1, 64'hCAFE_F00D_0BAD_BEEF, 4'h6);
    bus.RSP_READY = 1'b0;
    tick();
    checks++;
    if (bus.RSP_VALID !== 1'b1 || bus.RSP_LAST !== 1'b0 || bus.RSP_DATA !== 32'h0BAD_BEEF) begin
      errors++; $display("FAIL rm_beat1: v=%b last=%b data=%h, required 1 0 0badbeef",
                         bus.RSP_VALID, bus.RSP_LAST, bus.RSP_DATA);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.RSP_VALID !== 1'b0 || bus.RSP_DATA !== 32'h0) begin
      errors++; $display("FAIL rm_abort: v=%b data=%h, required 0 00000000", bus.RSP_VALID, bus.RSP_DATA);
    end
    rst_n = 1'b1;
    bus.RSP_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.RSP_VALID !== 1'b0) begin
        errors++; $display("FAIL rm_no_beat2 cycle=%0d: RSP_VALID=%b, required 0", i, bus.RSP_VALID);
      end
    end
    set_req(0, 1'b1, 3'b100, 1'b0, 64'h0000_0000_7F80_0000, 4'hC);
    set_req(1, 1'b1, 3'b100, 1'b0, 64'h0000_0000_FF80_0000, 4'hD);
    #1;
    checks++;
    if ({bus.REQ0_READY, bus.REQ1_READY} !== 2'b10) begin
      errors++; $display("FAIL rm_prio: ready0/1=%b, required 10", {bus.REQ0_READY, bus.REQ1_READY});
    end
    tick();
    set_req(0, 1'b0, 3'b000, 1'b0, 64'h0, 4'h0);
    set_req(1, 1'b0, 3'b000, 1'b0, 64'h0, 4'h0);
    tick();
    checks++;
    if (bus.RSP_VALID !== 1'b1 || bus.RSP_SRC !== 1'b0 || bus.RSP_TAG !== 4'hC) begin
      errors++; $display("FAIL rm_next_rsp: v=%b src=%b tag=%h, required 1 0 c",
                         bus.RSP_VALID, bus.RSP_SRC, bus.RSP_TAG);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.RSP_READY = 1'b1;
    set_req(0, 1'b0, 3'b000, 1'b0, 64'h0, 4'h0);
    set_req(1, 1'b0, 3'b000, 1'b0, 64'h0, 4'h0);
    test_reset();
    test_fclass_port0();
    test_dp_move();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
